// File: rtl/seg7_pkg.sv
// Shared constants and digit decode for the multiplexed 7-segment driver.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Non-BCD nibbles (10-15) render as a blank digit.
    function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
        if (nibble <= 4'd9) begin
            return SEG_TABLE[nibble];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_lookup(digit);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed common-anode 7-segment driver with a one-deep handshake buffer,
// tear-free commit at frame boundaries and an anti-ghost blank at each slot start.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 20000,
    parameter int unsigned BLANK_CYCLES = 200,
    parameter int unsigned LZ_SUPPRESS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    bcd_valid,
    output logic                    bcd_ready,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [4*NUM_DIGITS-1:0] pend_bcd;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;

    logic                    slot_end;
    logic                    boundary;
    logic                    take;
    logic                    in_blank;
    logic                    run_zero;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_suppress;
    logic [6:0]              cur_seg;

    always_comb begin
        slot_end = (presc == PW'(SCAN_DIV - 1));
        boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));
        take     = bcd_valid && bcd_ready;
        in_blank = (32'(presc) < BLANK_CYCLES);
    end

    // Walk down from the top digit; a digit is a leading zero while every
    // nibble from it upwards is zero. Digit 0 is never suppressed.
    always_comb begin
        lz_mask  = '0;
        run_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            run_zero = run_zero && (disp_bcd[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            lz_mask[NUM_DIGITS-1-k] = run_zero && (LZ_SUPPRESS != 0);
        end
    end

    always_comb begin
        cur_digit    = '0;
        cur_dp       = 1'b0;
        cur_suppress = 1'b0;
        an_sel       = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit    = disp_bcd[4*i +: 4];
                cur_dp       = disp_dp[i];
                cur_suppress = lz_mask[i];
                an_sel[i]    = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            bcd_ready  <= 1'b1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            frame_done <= boundary;

            // bcd_ready doubles as "pending empty"; commit and accept are
            // mutually exclusive because accept needs the buffer empty.
            if (boundary && !bcd_ready) begin
                disp_bcd  <= pend_bcd;
                disp_dp   <= pend_dp;
                bcd_ready <= 1'b1;
            end else if (take) begin
                pend_bcd  <= bcd_in;
                pend_dp   <= dp_in;
                bcd_ready <= 1'b0;
            end

            if (in_blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= an_sel;
                seg <= cur_suppress ? SEG_BLANK : cur_seg;
                dp  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed scenarios plus random traffic, checked
// cycle by cycle against a time-indexed reference model.
module tb_seg7_scan_mux;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 8;
    localparam int unsigned BC = 2;
    localparam logic [13:0] RST_VEC = {7'b1111111, 1'b1, 4'b1111, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic [13:0] obs_vec;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    seg7_scan_mux #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .LZ_SUPPRESS  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign obs_vec = {seg, dp, an, bcd_ready, frame_done};

    logic [6:0] seg_of [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    // Reference model: position in the scan comes straight from the cycle
    // count since reset; the buffer is a one-entry pending slot.
    int unsigned t;
    int unsigned m_presc;
    int unsigned m_idx;
    bit          m_bound;
    bit          m_take;
    bit          m_full;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic [3:0]  m_dpr;
    logic [3:0]  m_pdp;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic [13:0] exp_vec;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t       = 0;
            m_disp  = '0;
            m_dpr   = '0;
            m_full  = 1'b0;
            exp_vec = RST_VEC;
        end else begin
            m_presc = t % SD;
            m_idx   = (t / SD) % ND;
            m_bound = ((t % (SD * ND)) == (SD * ND - 1));
            if (m_presc < BC) begin
                m_an  = 4'b1111;
                m_seg = 7'b1111111;
                m_dp  = 1'b1;
            end else begin
                m_an  = ~(4'b0001 << m_idx);
                m_seg = (m_idx > 0 && (m_disp >> (4 * m_idx)) == 0) ? 7'b1111111
                                                                  : seg_of[m_disp[m_idx*4 +: 4]];
                m_dp  = ~m_dpr[m_idx];
            end
            m_take = bcd_valid && !m_full;
            if (m_bound && m_full) begin
                m_disp = m_pend;
                m_dpr  = m_pdp;
                m_full = 1'b0;
            end
            if (m_take) begin
                m_pend = bcd_in;
                m_pdp  = dp_in;
                m_full = 1'b1;
            end
            exp_vec = {m_seg, m_dp, m_an, !m_full, m_bound};
            t++;
        end
    end

    task automatic test_reset();
        rst       = 1'b1;
        bcd_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs_vec, RST_VEC);
        end
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_scan c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 1 || c == 2) begin
                vectors++;
                if (an !== 4'b1111) begin
                    miscompares++;
                    $display("FAIL reset_blank c%0d: got an=%b expected 1111", c, an);
                end
            end
            if (c == 3) begin
                vectors++;
                if ({an, seg} !== {4'b1110, 7'b0000001}) begin
                    miscompares++;
                    $display("FAIL reset_digit0: got an=%b seg=%b expected 1110 0000001", an, seg);
                end
            end
            if (c == 11) begin
                vectors++;
                if ({an, seg} !== {4'b1101, 7'b1111111}) begin
                    miscompares++;
                    $display("FAIL reset_lz_digit1: got an=%b seg=%b expected 1101 1111111", an, seg);
                end
            end
        end
    endtask

    task automatic test_load();
        bit seen;
        vectors++;
        if (bcd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_idle_ready: got %b expected 1", bcd_ready);
        end
        bcd_in    = 16'h1234;
        dp_in     = 4'b0000;
        bcd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bcd_valid = 1'b0;
        vectors++;
        if (bcd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ready_drop: got %b expected 0", bcd_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL load_scan: got %h expected %h", obs_vec, exp_vec);
            end
            seen = frame_done;
        end
        vectors++;
        if (!seen || bcd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_commit: got frame_done=%b ready=%b expected 1 1", seen, bcd_ready);
        end
        for (int c = 1; c <= 27; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL load_show: got %h expected %h", obs_vec, exp_vec);
            end
            if (c == 3) begin
                vectors++;
                if ({an, seg} !== {4'b1110, 7'b1001100}) begin
                    miscompares++;
                    $display("FAIL load_digit0: got an=%b seg=%b expected 1110 1001100", an, seg);
                end
            end
            if (c == 27) begin
                vectors++;
                if ({an, seg} !== {4'b0111, 7'b1001111}) begin
                    miscompares++;
                    $display("FAIL load_digit3: got an=%b seg=%b expected 0111 1001111", an, seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit accepted;
        bit will_take;
        bcd_in    = 16'h1234;
        dp_in     = 4'b0000;
        bcd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bcd_in   = 16'h5678;
        accepted = 1'b0;
        for (int c = 0; c < 80 && !accepted; c++) begin
            will_take = bcd_ready;
            if (will_take) begin
                vectors++;
                if (frame_done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_accept_after_commit: got frame_done=%b expected 1", frame_done);
                end
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bp_scan: got %h expected %h", obs_vec, exp_vec);
            end
            if (will_take) begin
                accepted  = 1'b1;
                bcd_valid = 1'b0;
            end
        end
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL bp_accept_timeout: got accepted=0 expected 1");
        end
        bcd_valid = 1'b0;
        for (int c = 0; c < 112; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bp_show: got %h expected %h", obs_vec, exp_vec);
            end
            if (c >= 80 && an == 4'b1110) begin
                vectors++;
                if (seg !== 7'b0000000) begin
                    miscompares++;
                    $display("FAIL bp_5678_digit0: got %b expected 0000000", seg);
                end
            end
        end
    endtask

    task automatic test_patterns();
        logic [6:0] want_seg;
        logic       want_dp;
        // 0x00A5: non-BCD digit blanks, leading zeros blank
        bcd_in    = 16'h00A5;
        dp_in     = 4'b0000;
        bcd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bcd_valid = 1'b0;
        for (int c = 0; c < 102; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL a5_scan: got %h expected %h", obs_vec, exp_vec);
            end
            if (c >= 70 && an != 4'b1111) begin
                want_seg = (an == 4'b1110) ? 7'b0100100 : 7'b1111111;
                vectors++;
                if ({seg, dp} !== {want_seg, 1'b1}) begin
                    miscompares++;
                    $display("FAIL a5_digit an=%b: got %b %b expected %b 1", an, seg, dp, want_seg);
                end
            end
        end
        // 0x1000: inner zeros shown, dp on digit 1 only
        bcd_in    = 16'h1000;
        dp_in     = 4'b0010;
        bcd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bcd_valid = 1'b0;
        for (int c = 0; c < 102; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL k1000_scan: got %h expected %h", obs_vec, exp_vec);
            end
            if (c >= 70 && an != 4'b1111) begin
                want_seg = (an == 4'b0111) ? 7'b1001111 : 7'b0000001;
                want_dp  = (an == 4'b1101) ? 1'b0 : 1'b1;
                vectors++;
                if ({seg, dp} !== {want_seg, want_dp}) begin
                    miscompares++;
                    $display("FAIL k1000_digit an=%b: got %b %b expected %b %b", an, seg, dp, want_seg, want_dp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int c = 0; c < 800; c++) begin
            w         = 16'($urandom);
            w         = w >> (4 * $urandom_range(0, 3));
            bcd_in    = w;
            dp_in     = 4'($urandom);
            bcd_valid = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
        bcd_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit sent;
        sent = 1'b0;
        bcd_in    = 16'h9999;
        dp_in     = 4'b1111;
        for (int c = 0; c < 80 && !sent; c++) begin
            sent      = bcd_ready;
            bcd_valid = bcd_ready;
            @(posedge clk);
            @(negedge clk);
            bcd_valid = 1'b0;
        end
        vectors++;
        if (!sent || bcd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_pending: got sent=%b ready=%b expected 1 0", sent, bcd_ready);
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL midop_async: got %h expected %h", obs_vec, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL midop_scan c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 3 || c == 35) begin
                vectors++;
                if ({an, seg, dp} !== {4'b1110, 7'b0000001, 1'b1}) begin
                    miscompares++;
                    $display("FAIL midop_zero c%0d: got an=%b seg=%b dp=%b expected 1110 0000001 1", c, an, seg, dp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_patterns();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
